// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the soc_bus CPU-to-RAM/IO bridge.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAM_ACC = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam int unsigned IO_SEL_BIT = 22;
  localparam int unsigned IDX_LSB    = 2;
  localparam int unsigned IDX_MSB    = 4;
  localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/soc_bus_decode.sv
// Region/channel decode of a CPU address and read-data mux for the peripheral channels.
module soc_bus_decode
  import soc_bus_pkg::*;
#(
  parameter int NUM_PERIPH = 4
) (
  input  logic                    i_io_bit,
  input  logic [2:0]              i_idx,
  input  logic [2:0]              i_chan,
  input  logic [32*NUM_PERIPH-1:0] i_per_rdata,
  output logic                    o_is_io,
  output logic [2:0]              o_idx,
  output logic                    o_idx_ok,
  output logic [31:0]             o_chan_rdata
);

  assign o_is_io  = i_io_bit;
  assign o_idx    = i_idx;
  assign o_idx_ok = (int'(i_idx) < NUM_PERIPH);

  always_comb begin
    o_chan_rdata = '0;
    for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
      if (i_chan == 3'(i)) o_chan_rdata = i_per_rdata[32*i +: 32];
    end
  end

endmodule

// File: rtl/soc_bus.sv
// CPU bus bridge: routes single transactions to the RAM or to one of NUM_PERIPH IO channels.
// Optional IO wait timeout enabled by defining SOC_BUS_TIMEOUT_EN.
module soc_bus
  import soc_bus_pkg::*;
#(
  parameter int NUM_PERIPH = 4,
  parameter int RAM_ADDR_W = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  input  logic                     mem_rstrb,
  output logic [31:0]              mem_rdata,
  output logic                     mem_busy,
  output logic                     mem_ready,
  output logic [31:0]              ram_addr,
  output logic [31:0]              ram_wdata,
  output logic [3:0]               ram_wstrb,
  output logic                     ram_rstrb,
  input  logic [31:0]              ram_rdata,
  output logic [NUM_PERIPH-1:0]    per_sel,
  output logic [31:0]              per_addr,
  output logic [31:0]              per_wdata,
  output logic [3:0]               per_wstrb,
  input  logic [32*NUM_PERIPH-1:0] per_rdata,
  input  logic [NUM_PERIPH-1:0]    per_ack,
  output logic [31:0]              cycle,
  output logic                     bus_err
);

  localparam logic [31:0] RAM_MASK =
    (RAM_ADDR_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << RAM_ADDR_W) - 32'd1);

  state_t                r_state, w_next;
  logic [31:0]           r_addr, r_wdata, r_rdata, r_cycle;
  logic [3:0]            r_wstrb, r_ram_wstrb;
  logic                  r_ram_rstrb, r_is_read, r_ram_wait, r_bus_err, r_chan_ok;
  logic [2:0]            r_chan;
  logic [NUM_PERIPH-1:0] r_sel;

  logic                  w_req, w_is_io, w_idx_ok, w_ack, w_tmo_hit;
  logic [2:0]            w_idx;
  logic [31:0]           w_chan_rdata;

  soc_bus_decode #(.NUM_PERIPH(NUM_PERIPH)) u_decode (
    .i_io_bit     (mem_addr[IO_SEL_BIT]),
    .i_idx        (mem_addr[IDX_MSB:IDX_LSB]),
    .i_chan       (r_chan),
    .i_per_rdata  (per_rdata),
    .o_is_io      (w_is_io),
    .o_idx        (w_idx),
    .o_idx_ok     (w_idx_ok),
    .o_chan_rdata (w_chan_rdata)
  );

  assign w_req = mem_rstrb | (|mem_wstrb);
  assign w_ack = |(per_ack & r_sel);

`ifdef SOC_BUS_TIMEOUT_EN
  logic [31:0] r_tmo;
  assign w_tmo_hit = (r_tmo == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || r_state != ST_IO_WAIT) r_tmo <= '0;
    else                              r_tmo <= r_tmo + 32'd1;
  end
`else
  // Without the timeout feature an IO wait never expires.
  assign w_tmo_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_req) w_next = w_is_io ? ST_IO_WAIT : ST_RAM_ACC;
      ST_RAM_ACC: if (r_ram_wait) w_next = ST_RESP;
      ST_IO_WAIT: if (!r_chan_ok || w_ack || w_tmo_hit) w_next = ST_RESP;
      ST_RESP:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_ram_wstrb <= '0;
      r_ram_rstrb <= 1'b0;
      r_is_read   <= 1'b0;
      r_ram_wait  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_chan      <= '0;
      r_chan_ok   <= 1'b0;
      r_sel       <= '0;
    end else begin
      r_ram_wstrb <= '0;
      r_ram_rstrb <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr     <= mem_addr;
            r_wdata    <= mem_wdata;
            r_wstrb    <= mem_wstrb;
            r_is_read  <= mem_rstrb && (mem_wstrb == 4'h0);
            r_chan     <= w_idx;
            r_chan_ok  <= w_idx_ok;
            r_ram_wait <= 1'b0;
            if (!w_is_io) begin
              r_ram_wstrb <= mem_wstrb;
              r_ram_rstrb <= mem_rstrb && (mem_wstrb == 4'h0);
            end else if (w_idx_ok) begin
              r_sel <= NUM_PERIPH'(1) << w_idx;
            end
          end
        end
        // Second RAM_ACC cycle is where the RAM read data becomes valid.
        ST_RAM_ACC: begin
          r_ram_wait <= 1'b1;
          if (r_ram_wait && r_is_read) r_rdata <= ram_rdata;
        end
        ST_IO_WAIT: begin
          if (!r_chan_ok) begin
            r_bus_err <= 1'b1;
            if (r_is_read) r_rdata <= '0;
          end else if (w_ack) begin
            r_sel <= '0;
            if (r_is_read) r_rdata <= w_chan_rdata;
          end else if (w_tmo_hit) begin
            r_sel     <= '0;
            r_bus_err <= 1'b1;
            if (r_is_read) r_rdata <= ERR_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_cycle <= '0;
    else     r_cycle <= r_cycle + 32'd1;
  end

  assign mem_rdata = r_rdata;
  assign mem_busy  = (r_state == ST_RAM_ACC) || (r_state == ST_IO_WAIT);
  assign mem_ready = (r_state == ST_RESP);
  assign ram_addr  = r_addr & RAM_MASK;
  assign ram_wdata = r_wdata;
  assign ram_wstrb = r_ram_wstrb;
  assign ram_rstrb = r_ram_rstrb;
  assign per_sel   = r_sel;
  assign per_addr  = r_addr;
  assign per_wdata = r_wdata;
  assign per_wstrb = r_wstrb;
  assign cycle     = r_cycle;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_soc_bus.sv
// Directed bench for soc_bus with NUM_PERIPH=4; define SOC_BUS_TIMEOUT_EN to exercise the IO timeout.
module tb_soc_bus;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_wstrb;
  logic         mem_rstrb, mem_busy, mem_ready;
  logic [31:0]  ram_addr, ram_wdata, ram_rdata;
  logic [3:0]   ram_wstrb;
  logic         ram_rstrb;
  logic [3:0]   per_sel, per_ack, per_wstrb;
  logic [31:0]  per_addr, per_wdata, cycle;
  logic [127:0] per_rdata;
  logic         bus_err;
  logic [31:0]  ram_word;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // RAM model: data valid one cycle after the read strobe, garbage otherwise.
  always @(posedge clk) ram_rdata <= ram_rstrb ? ram_word : 32'h0BAD_0BAD;

  soc_bus #(.NUM_PERIPH(4), .RAM_ADDR_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_ready(mem_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rstrb(ram_rstrb),
    .ram_rdata(ram_rdata),
    .per_sel(per_sel), .per_addr(per_addr), .per_wdata(per_wdata), .per_wstrb(per_wstrb),
    .per_rdata(per_rdata), .per_ack(per_ack),
    .cycle(cycle), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_req();
    mem_rstrb = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  initial begin
    rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; mem_rstrb = 1'b0;
    per_ack = '0; ram_word = '0;
    per_rdata = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    repeat (3) tick();
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_busy",  32'(mem_busy),  32'd0);
    chk("rst_sel",   32'(per_sel),   32'd0);
    chk("rst_rstrb", 32'(ram_rstrb), 32'd0);
    chk("rst_err",   32'(bus_err),   32'd0);
    chk("rst_rdata", mem_rdata,      32'd0);
    chk("rst_cycle", cycle,          32'd0);
    rst = 1'b0;
    tick();
    chk("cycle_1", cycle, 32'd1);

    // RAM read: mem_ready three cycles after the request.
    ram_word = 32'h1234_5678; mem_addr = 32'h0000_0010; mem_rstrb = 1'b1;
    tick(); clr_req();
    chk("rd_busy1",  32'(mem_busy),  32'd1);
    chk("rd_rstrb1", 32'(ram_rstrb), 32'd1);
    chk("rd_addr",   ram_addr,       32'h0000_0010);
    chk("rd_rdy1",   32'(mem_ready), 32'd0);
    tick();
    chk("rd_rstrb2", 32'(ram_rstrb), 32'd0);
    chk("rd_rdy2",   32'(mem_ready), 32'd0);
    tick();
    chk("rd_rdy3",   32'(mem_ready), 32'd1);
    chk("rd_busy3",  32'(mem_busy),  32'd0);
    chk("rd_data",   mem_rdata,      32'h1234_5678);
    tick();
    chk("rd_rdy4",   32'(mem_ready), 32'd0);
    chk("rd_hold",   mem_rdata,      32'h1234_5678);

    // Simultaneous read and write strobes: write only.
    ram_word = 32'h7777_7777;
    mem_addr = 32'h0000_0020; mem_wdata = 32'h1111_2222; mem_wstrb = 4'h3; mem_rstrb = 1'b1;
    tick(); clr_req();
    chk("rw_wstrb", 32'(ram_wstrb), 32'h3);
    chk("rw_rstrb", 32'(ram_rstrb), 32'd0);
    chk("rw_wdata", ram_wdata,      32'h1111_2222);
    tick();
    chk("rw_wstrb2", 32'(ram_wstrb), 32'h0);
    tick();
    chk("rw_ready", 32'(mem_ready), 32'd1);
    chk("rw_rdata", mem_rdata,      32'h1234_5678);
    tick();

    // IO write to ch1; a stray ack and a stray request arrive while busy.
    mem_addr = 32'h0040_0004; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF;
    tick(); clr_req();
    chk("iow_sel1",  32'(per_sel),   32'h2);
    chk("iow_addr",  per_addr,       32'h0040_0004);
    chk("iow_wdata", per_wdata,      32'hCAFE_F00D);
    chk("iow_wstrb", 32'(per_wstrb), 32'hF);
    chk("iow_busy",  32'(mem_busy),  32'd1);
    per_ack = 4'b0100; mem_addr = 32'h0000_0030; mem_rstrb = 1'b1;
    tick();
    chk("iow_sel2",  32'(per_sel),   32'h2);
    chk("iow_rdy2",  32'(mem_ready), 32'd0);
    chk("iow_noram", 32'(ram_rstrb), 32'd0);
    per_ack = 4'b0000; mem_rstrb = 1'b0;
    tick();
    chk("iow_sel3",  32'(per_sel),   32'h2);
    per_ack = 4'b0010;
    tick(); per_ack = 4'b0000;
    chk("iow_sel4",  32'(per_sel),   32'h0);
    chk("iow_ready", 32'(mem_ready), 32'd1);
    chk("iow_rdata", mem_rdata,      32'h1234_5678);
    tick();
    chk("iow_idle_rdy",  32'(mem_ready), 32'd0);
    chk("iow_idle_busy", 32'(mem_busy),  32'd0);

    // IO read from ch2 with immediate ack.
    mem_addr = 32'h0040_0008; mem_rstrb = 1'b1;
    tick(); clr_req();
    chk("ior_sel", 32'(per_sel), 32'h4);
    per_ack = 4'b0100;
    tick(); per_ack = 4'b0000;
    chk("ior_ready", 32'(mem_ready), 32'd1);
    chk("ior_rdata", mem_rdata,      32'hA5A5_0002);
    chk("ior_sel0",  32'(per_sel),   32'h0);
    tick();

    // Read of channel 5 with only four channels present.
    mem_addr = 32'h0040_0014; mem_rstrb = 1'b1;
    tick(); clr_req();
    chk("bad_sel",  32'(per_sel),  32'h0);
    chk("bad_busy", 32'(mem_busy), 32'd1);
    chk("bad_err0", 32'(bus_err),  32'd0);
    tick();
    chk("bad_ready", 32'(mem_ready), 32'd1);
    chk("bad_rdata", mem_rdata,      32'd0);
    chk("bad_err1",  32'(bus_err),   32'd1);
    tick();

    // Read of ch3 with a late or absent ack.
    mem_addr = 32'h0040_000C; mem_rstrb = 1'b1;
    tick(); clr_req();
`ifdef SOC_BUS_TIMEOUT_EN
    repeat (14) tick();
    chk("tmo_rdy15", 32'(mem_ready), 32'd0);
    chk("tmo_sel15", 32'(per_sel),   32'h8);
    tick();
    chk("tmo_ready", 32'(mem_ready), 32'd1);
    chk("tmo_rdata", mem_rdata,      32'hDEAD_BEEF);
    chk("tmo_err",   32'(bus_err),   32'd1);
    chk("tmo_sel",   32'(per_sel),   32'h0);
`else
    repeat (19) tick();
    chk("wait_rdy20",  32'(mem_ready), 32'd0);
    chk("wait_busy20", 32'(mem_busy),  32'd1);
    chk("wait_sel20",  32'(per_sel),   32'h8);
    per_ack = 4'b1000;
    tick(); per_ack = 4'b0000;
    chk("wait_ready", 32'(mem_ready), 32'd1);
    chk("wait_rdata", mem_rdata,      32'hA5A5_0003);
    chk("wait_err",   32'(bus_err),   32'd1);
`endif
    tick();

    // Reset while waiting on ch0.
    mem_addr = 32'h0040_0000; mem_wdata = 32'h0000_00AA; mem_wstrb = 4'hF;
    tick(); clr_req();
    chk("rsw_sel1", 32'(per_sel), 32'h1);
    rst = 1'b1;
    tick();
    chk("rsw_sel",   32'(per_sel),   32'h0);
    chk("rsw_busy",  32'(mem_busy),  32'd0);
    chk("rsw_ready", 32'(mem_ready), 32'd0);
    chk("rsw_cycle", cycle,          32'd0);
    chk("rsw_err",   32'(bus_err),   32'd0);
    chk("rsw_rdata", mem_rdata,      32'd0);
    rst = 1'b0;
    tick();
    chk("rsw_ready2", 32'(mem_ready), 32'd0);
    chk("rsw_cycle2", cycle,          32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/soc_bus.md
SOC_BUS -- requirements
Module: soc_bus

Interface
REQ-001 Parameter NUM_PERIPH, default 4, number of peripheral channels (1..8).
REQ-002 Parameter RAM_ADDR_W, default 16, byte-address width of the RAM region.
REQ-003 Parameter TIMEOUT, default 15, maximum peripheral wait cycles before forced completion.
REQ-004 Port clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port mem_addr  in  32  CPU byte address.
REQ-007 Port mem_wdata  in  32  CPU write data.
REQ-008 Port mem_wstrb  in  4  CPU byte write enables; nonzero starts a write.
REQ-009 Port mem_rstrb  in  1  CPU read request pulse.
REQ-010 Port mem_rdata  out  32  read data, valid when mem_ready=1.
REQ-011 Port mem_busy  out  1  transaction in flight; CPU stalls.
REQ-012 Port mem_ready  out  1  one-cycle completion pulse.
REQ-013 Port ram_addr  out  32  registered address to the program/data RAM.
REQ-014 Port ram_wdata, ram_wstrb, ram_rstrb  out  32/4/1  registered RAM write data, byte enables and read strobe.
REQ-015 Port ram_rdata  in  32  RAM read data, valid one cycle after ram_rstrb.
REQ-016 Port per_sel  out  NUM_PERIPH  one-hot peripheral select, held until ack.
REQ-017 Port per_addr, per_wdata, per_wstrb  out  32/32/4  shared peripheral request fields.
REQ-018 Port per_rdata  in  32*NUM_PERIPH  concatenated peripheral read data, channel i at bits [32i+31:32i].
REQ-019 Port per_ack  in  NUM_PERIPH  per-channel completion.
REQ-020 Port cycle  out  32  free-running cycle counter.
REQ-021 Port bus_err  out  1  sticky error flag.

Function
REQ-022 Decode: mem_addr[22]=0 selects RAM; mem_addr[22]=1 selects IO, channel index = mem_addr[4:2].
REQ-023 FSM states IDLE, RAM_ACC, IO_WAIT, RESP; reset state IDLE.
REQ-024 IDLE: request (mem_rstrb or nonzero mem_wstrb) latches addr/wdata/wstrb -> RAM_ACC or IO_WAIT; mem_busy=1 from the next cycle.
REQ-025 Simultaneous rstrb and wstrb: write only; mem_rdata not updated.
REQ-026 Requests arriving while mem_busy=1 are ignored.
REQ-027 RAM_ACC: strobes asserted for exactly one cycle -> RESP; RAM read latency 3 cycles from request to mem_ready.
REQ-028 IO_WAIT: per_sel bit held until the matching per_ack; ack cycle captures that channel's per_rdata -> RESP.
REQ-029 per_ack on a non-selected channel is ignored.
REQ-030 IO index >= NUM_PERIPH: no per_sel; next cycle -> RESP, rdata 0, bus_err set.
REQ-031 RESP: mem_ready=1 and mem_busy=0 for one cycle, mem_rdata = captured data -> IDLE.
REQ-032 mem_rdata holds its value until the next read completes.
REQ-033 cycle increments every cycle, wraps 0xFFFF_FFFF -> 0.
REQ-034 bus_err clears only on rst.

Reset
REQ-035 rst=1 forces IDLE mid-transaction; in-flight access dropped without mem_ready; per_sel and strobes deassert the following cycle.
REQ-036 Reset values: all outputs 0; cycle=0; bus_err=0.

Configuration
REQ-037 Macro SOC_BUS_TIMEOUT_EN defined: IO_WAIT counts cycles; after TIMEOUT cycles without ack -> RESP, rdata 32'hDEAD_BEEF, bus_err set.
REQ-038 Macro absent: IO_WAIT waits indefinitely; no timeout counter; bus_err set only by REQ-030.

Structure
REQ-039 Package soc_bus_pkg: state enum, IO_SEL_BIT (22), index field positions, ERR_RDATA (32'hDEAD_BEEF).
REQ-040 One sub-module soc_bus_decode: combinational region/channel decode and per_rdata mux.

Verification
REQ-041 Read 0x0000_0010, RAM returns 0x1234_5678 -> mem_ready 3 cycles after rstrb, mem_rdata=0x1234_5678.
REQ-042 Write 0x0040_0004, wstrb=4'hF, ack on ch1 after 2 cycles -> per_sel=4'b0010 for 3 cycles, then mem_ready.
REQ-043 Read 0x0040_0014 with NUM_PERIPH=4 -> no per_sel, mem_rdata=0, bus_err=1.
REQ-044 SOC_BUS_TIMEOUT_EN, TIMEOUT=15, no ack -> mem_ready after 15 wait cycles, mem_rdata=0xDEAD_BEEF, bus_err=1.
REQ-045 rst asserted in IO_WAIT -> next cycle per_sel=0, mem_busy=0, no mem_ready; cycle=0.
REQ-046 rstrb and wstrb=4'h3 together -> RAM write only, mem_rdata unchanged.
